// File: rtl/instr_mem_loader_if.sv
// Boot-loader stream and instruction-memory write bus.
// Handshake: a byte moves on a rising edge where i_byte_valid && o_byte_ready;
// o_byte_ready is registered and depends only on loader state, the source may
// hold i_byte_valid high while ready is low and nothing is consumed; o_we is a
// single-cycle strobe qualifying o_adr/o_wdata.
interface instr_mem_loader_if #(
  parameter int AW = 64
);
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_byte_ready;
  logic          o_we;
  logic [AW-1:0] o_adr;
  logic [31:0]   o_wdata;

  // Loader side
  modport slave (
    input  i_byte_valid, i_byte,
    output o_byte_ready, o_we, o_adr, o_wdata
  );

  // Stream source / memory observer side
  modport master (
    output i_byte_valid, i_byte,
    input  o_byte_ready, o_we, o_adr, o_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory writer. Receives a framed byte stream
// (4-byte little-endian word count, payload, 1-byte XOR checksum of the
// payload), packs payload into little-endian words, writes one word per
// WRITE cycle from BASE_ADR upward and releases the core only after a load
// with a matching checksum.
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif
`ifndef TEXT_HI
`define TEXT_HI 32'h0000_0FFF
`endif

module instr_mem_loader #(
  parameter logic [1:0]  XLEN      = `XLEN_64b,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int          MAX_WORDS = (`TEXT_HI + 1) >> 2,
  localparam int         AW        = 1 << (XLEN + 4)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  instr_mem_loader_if.slave   bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic                o_cpu_hold,
  output logic [31:0]         o_word_cnt,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] len;
  logic [31:0] len_full;
  logic [7:0]  csum;
  logic [31:0] wdata;
  logic [31:0] word_cnt;
  logic [31:0] adr32;
  logic        ready;
  logic        xfer;

  assign xfer        = bus.i_byte_valid && ready;
  // Length word as it stands once the current (4th) byte is merged in
  assign len_full    = {bus.i_byte, len[23:0]};
  assign adr32       = BASE_ADR + {word_cnt[29:0], 2'b00};

  assign bus.o_byte_ready = ready;
  assign bus.o_wdata      = wdata;
  assign bus.o_adr        = AW'(adr32);
  assign o_word_cnt       = word_cnt;
  assign o_dbg_state      = state;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (xfer && byte_cnt == 2'd3) begin
          if (len_full == 32'd0)                  state_nxt = S_CSUM;
          else if (len_full > 32'(MAX_WORDS))     state_nxt = S_ERR;
          else                                    state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = (word_cnt + 32'd1 == len) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) state_nxt = (bus.i_byte == csum) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, registered status outputs and datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      ready      <= 1'b0;
      bus.o_we   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_cpu_hold <= 1'b1;
      byte_cnt   <= 2'd0;
      len        <= 32'd0;
      csum       <= 8'd0;
      wdata      <= 32'd0;
      word_cnt   <= 32'd0;
    end else begin
      state      <= state_nxt;
      // Outputs are decoded from the next state so they line up with it
      ready      <= (state_nxt == S_LEN) || (state_nxt == S_DATA) ||
                    (state_nxt == S_CSUM);
      bus.o_we   <= (state_nxt == S_WRITE);
      o_busy     <= (state_nxt == S_LEN) || (state_nxt == S_DATA) ||
                    (state_nxt == S_WRITE) || (state_nxt == S_CSUM);
      o_done     <= (state_nxt == S_DONE);
      o_err      <= (state_nxt == S_ERR);
      o_cpu_hold <= (state_nxt != S_DONE);

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            byte_cnt <= 2'd0;
            csum     <= 8'd0;
            word_cnt <= 32'd0;
            len      <= 32'd0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            len[8*byte_cnt +: 8] <= bus.i_byte;
            byte_cnt             <= byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (xfer) begin
            wdata[8*byte_cnt +: 8] <= bus.i_byte;
            csum                   <= csum ^ bus.i_byte;
            byte_cnt               <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of framed loads plus hand-written
// reset-abort and reset-state sequences. Expected writes go into a queue that
// a write monitor drains.
module tb_instr_mem_loader;
  localparam int          AW        = 64;
  localparam logic [31:0] BASE      = 32'h0000_0100;
  localparam int          MAXW      = 16;
  localparam int          W         = AW + 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, err, cpu_hold;
  logic [31:0] word_cnt;
  logic [2:0]  dbg_state;

  instr_mem_loader_if #(.AW(AW)) bif ();

  instr_mem_loader #(
    .XLEN(2'd2), .BASE_ADR(BASE), .MAX_WORDS(MAXW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .bus(bif),
    .o_busy(busy), .o_done(done), .o_err(err), .o_cpu_hold(cpu_hold),
    .o_word_cnt(word_cnt), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int n_we   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (bif.o_we === 1'b1) begin
      n_we++;
      if (exp_q.size() == 0) chk("unexpected_write", {bif.o_adr, bif.o_wdata}, '0);
      else chk("write", {bif.o_adr, bif.o_wdata}, exp_q.pop_front());
      chk("ready_in_write", W'(bif.o_byte_ready), W'(0));
    end
  end

  // Drivers
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cnt;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bif.i_byte_valid = 1'b0;
        bif.i_byte       = $urandom_range(0, 255);
        @(posedge clk); #1;
      end
    end
    bif.i_byte_valid = 1'b1;
    bif.i_byte       = b;
    cnt = 0;
    while (bif.o_byte_ready !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 20) chk("ready_timeout", W'(cnt), W'(0));
    @(posedge clk); #1;
    bif.i_byte_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    bit          gaps;
    bit          exp_done;
    int          exp_writes;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] words[2];
    int nw;
    words[0] = v.w0;
    words[1] = v.w1;
    nw = (v.len > 32'(MAXW)) ? 0 : int'(v.len);
    n_we = 0;
    for (int i = 0; i < nw; i++)
      exp_q.push_back({AW'(BASE + 32'(4 * i)), words[i]});
    pulse_start();
    chk($sformatf("v%0d_busy_after_start", idx), W'(busy), W'(1));
    for (int i = 0; i < 4; i++) send_byte(v.len[8*i +: 8], v.gaps);
    if (v.len <= 32'(MAXW)) begin
      for (int w = 0; w < nw; w++) begin
        for (int i = 0; i < 4; i++) send_byte(words[w][8*i +: 8], v.gaps);
        chk($sformatf("v%0d_we_latency", idx), W'(bif.o_we), W'(1));
      end
      send_byte(v.csum, v.gaps);
    end
    chk($sformatf("v%0d_done", idx), W'(done), W'(v.exp_done));
    chk($sformatf("v%0d_err", idx), W'(err), W'(!v.exp_done));
    chk($sformatf("v%0d_cpu_hold", idx), W'(cpu_hold), W'(!v.exp_done));
    chk($sformatf("v%0d_busy", idx), W'(busy), W'(0));
    chk($sformatf("v%0d_ready", idx), W'(bif.o_byte_ready), W'(0));
    chk($sformatf("v%0d_state", idx), W'(dbg_state), W'(v.exp_done ? 3'd5 : 3'd6));
    chk($sformatf("v%0d_word_cnt", idx), W'(word_cnt), W'(v.exp_writes));
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("v%0d_n_writes", idx), W'(n_we), W'(v.exp_writes));
    chk($sformatf("v%0d_queue_empty", idx), W'(exp_q.size()), W'(0));
  endtask

  initial begin
    //                len             w0            w1            csum   gaps done writes
    vecs[0] = '{32'd2,          32'h0000_0013, 32'h0010_0093, 8'h90, 1'b0, 1'b1, 2};
    vecs[1] = '{32'd2,          32'h0000_0013, 32'h0010_0093, 8'h91, 1'b0, 1'b0, 2};
    vecs[2] = '{32'(MAXW + 1),  32'h0,         32'h0,         8'h00, 1'b0, 1'b0, 0};
    vecs[3] = '{32'd0,          32'h0,         32'h0,         8'h00, 1'b0, 1'b1, 0};
    vecs[4] = '{32'd0,          32'h0,         32'h0,         8'h01, 1'b0, 1'b0, 0};
    vecs[5] = '{32'd2,          32'h0000_0013, 32'h0010_0093, 8'h90, 1'b1, 1'b1, 2};
    vecs[6] = '{32'd1,          32'hDEAD_BEEF, 32'h0,         8'h22, 1'b1, 1'b1, 1};

    rst = 1'b1;
    start = 1'b0;
    bif.i_byte_valid = 1'b0;
    bif.i_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_state", W'(dbg_state), W'(0));
    chk("rst_we", W'(bif.o_we), W'(0));
    chk("rst_ready", W'(bif.o_byte_ready), W'(0));
    chk("rst_flags", W'({busy, done, err, cpu_hold}), W'(4'b0001));
    chk("rst_word_cnt", W'(word_cnt), W'(0));
    chk("rst_adr", W'(bif.o_adr), W'(BASE));
    chk("rst_wdata", W'(bif.o_wdata), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset after 5 payload bytes abandons the load
    n_we = 0;
    exp_q.push_back({AW'(BASE), 32'h0000_0013});
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(vecs[0].len[8*i +: 8], 1'b0);
    for (int i = 0; i < 4; i++) send_byte(vecs[0].w0[8*i +: 8], 1'b0);
    send_byte(vecs[0].w1[7:0], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", W'(dbg_state), W'(0));
    chk("abort_we", W'(bif.o_we), W'(0));
    chk("abort_cpu_hold", W'(cpu_hold), W'(1));
    chk("abort_word_cnt", W'(word_cnt), W'(0));
    chk("abort_busy", W'(busy), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_n_writes", W'(n_we), W'(1));
    run_vec(vecs[0], 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", total);
    $fatal(1);
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Boot-time writer for the byte-addressed instruction memory, opposite end of the instruction-fetch read port.
- Accepts a framed byte stream over a valid/ready handshake: 4-byte word count, payload, 1-byte XOR checksum.
- Packs payload bytes into little-endian 32-bit words and issues one write per word starting at BASE_ADR.
- Holds the core in reset until a load completes with a matching checksum.

Parameters:
XLEN, `XLEN_64b, 2-bit width encoding; address width AW = 1<<(XLEN+4)
BASE_ADR, 0, byte address of first written word; must be 4-aligned
MAX_WORDS, (`TEXT_HI+1)>>2, largest accepted word count

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous, active-high reset
i_start  in  1  begin a load (sampled in IDLE, DONE, ERR)
i_byte_valid  in  1  stream byte valid
i_byte  in  8  stream byte
o_byte_ready  out  1  loader accepts a byte this cycle
o_we  out  1  instruction-memory write strobe, one cycle per word
o_adr  out  AW  byte address of word being written
o_wdata  out  32  word; byte_0 = [7:0] = first received byte
o_busy  out  1  load in progress
o_done  out  1  load finished, checksum OK
o_err  out  1  length overflow or checksum mismatch
o_cpu_hold  out  1  keeps core in reset
o_word_cnt  out  32  words written so far in current load

Behaviour:
- Reset (sync, i_rst=1 at edge): state IDLE; o_we=0, o_byte_ready=0, o_busy=0, o_done=0, o_err=0, o_cpu_hold=1, o_word_cnt=0, o_adr=BASE_ADR, o_wdata=0. Reset mid-load abandons the load and suppresses any pending write from the following edge.
- Transfer occurs on an edge where i_byte_valid && o_byte_ready. o_byte_ready is a registered function of state only (no combinational path from i_byte_valid).
- States:
  - IDLE: ready=0. i_start -> LEN; clear byte counter, checksum, o_word_cnt.
  - LEN: ready=1. Collect 4 bytes little-endian into len.
    - len==0 -> CSUM.
    - len>MAX_WORDS -> ERR.
    - Otherwise -> DATA.
  - DATA: ready=1. Collect 4 bytes into o_wdata lanes 0..3, XOR each into checksum. After the 4th byte -> WRITE.
  - WRITE: ready=0. o_we=1 for exactly this cycle, o_adr=BASE_ADR+4*o_word_cnt. Next edge: o_word_cnt+1; -> CSUM if o_word_cnt+1==len, else DATA.
  - CSUM: ready=1. Receive 1 byte. Equal to checksum -> DONE, else -> ERR.
  - DONE: o_done=1, o_cpu_hold=0, ready=0. i_start -> LEN; o_done clears and o_cpu_hold rises again.
  - ERR: o_err=1, o_cpu_hold=1, ready=0. i_start -> LEN; o_err clears.
- o_busy=1 in LEN, DATA, WRITE, CSUM. i_start while busy is ignored.
- Word-count comparison, address and o_word_cnt arithmetic use 32 bits. o_adr is truncated to AW and wraps modulo 2^AW. BASE_ADR+4*MAX_WORDS must not exceed `TEXT_HI+1; the parameter setting must guarantee this.
- Gaps in i_byte_valid stall the FSM with no state change. Bytes offered while ready=0 are not consumed.
- Latency: write strobe on the cycle after the 4th byte of a word. DONE one cycle after the checksum byte.

Test Plan:
- Reset then i_start, stream len=02 00 00 00, payload 13 00 00 00 93 00 10 00, csum 0x90 -> o_we pulses with (BASE_ADR, 0x00000013) and (BASE_ADR+4, 0x00100093); o_done=1, o_cpu_hold=0, o_word_cnt=2.
- Same stream with csum 0x91 -> two writes still occur, o_err=1, o_done=0, o_cpu_hold=1.
- len=MAX_WORDS+1 -> ERR right after the 4th length byte; zero o_we pulses; o_byte_ready=0.
- len=0 then csum 0x00 -> DONE with no writes; csum 0x01 -> ERR.
- Random i_byte_valid gaps (~50%) on the first stream -> identical write sequence; no byte lost or duplicated; ready low during WRITE.
- Assert i_rst after 5 payload bytes -> next cycle IDLE, o_we=0, o_cpu_hold=1, o_word_cnt=0; a fresh load then completes correctly.
